// File: rtl/ps2_key_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ps2_pkg
// Purpose  : Shared types and constants for the PS/2 key decoder. This
//            package holds the frame FSM state encoding, the prefix byte
//            values and the device-response classifier.
// Revision : 1.0  initial release
// ============================================================================
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_t;

    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_BRK    = 8'hF0;
    localparam logic [7:0] PS2_PAUSE  = 8'hE1;
    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    // The keyboard sends these bytes as acknowledgements, self-test results
    // and errors. They are not key codes.
    function automatic logic is_response(input logic [7:0] code);
        logic r;
        case (code)
            8'h00, 8'hAA, 8'hEE, 8'hFA,
            8'hFC, 8'hFD, 8'hFE, 8'hFF: r = 1'b1;
            default:                    r = 1'b0;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_key_decoder_if.sv
`default_nettype none
// ============================================================================
// Module   : ps2_key_decoder_if
// Purpose  : Carries the raw PS/2 lines into the decoder and the decoded key
//            event word and frame-error pulse out of it.
// Signals  : ps2_clk_in  raw PS/2 clock (idle high)
//            ps2_data_in raw PS/2 data  (idle high)
//            ps2_key     [10] toggle, [9] make, [8] E0 seen, [7:0] code
//            frame_err   one-cycle error pulse
// Modports : master = line driver / event consumer, slave = decoder
// Revision : 1.0  initial release
// ============================================================================
interface ps2_key_decoder_if;
    logic        ps2_clk_in;
    logic        ps2_data_in;
    logic [10:0] ps2_key;
    logic        frame_err;

    modport master (output ps2_clk_in, output ps2_data_in,
                    input  ps2_key,    input  frame_err);
    modport slave  (input  ps2_clk_in, input  ps2_data_in,
                    output ps2_key,    output frame_err);
endinterface
`default_nettype wire

// File: rtl/ps2_key_decoder_line_filter.sv
`default_nettype none
// ============================================================================
// Module   : ps2_line_filter
// Purpose  : Brings one asynchronous PS/2 line into the clk_sys domain with a
//            two-flop synchroniser. It then debounces the line, so the
//            filtered output only follows after FILTER_LEN consecutive
//            samples that differ from it.
// Ports    : clk_sys in  system clock
//            reset   in  synchronous active-high reset
//            i_line  in  raw line
//            o_filt  out filtered line (resets high = idle)
// Revision : 1.0  initial release
// ============================================================================
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic i_line,
    output logic o_filt
);
    localparam int CNT_W = $clog2(FILTER_LEN);

    logic             r_meta;
    logic             r_sync;
    logic             r_filt;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_filt <= 1'b1;
            r_cnt  <= '0;
        end else begin
            r_meta <= i_line;
            r_sync <= r_meta;
            // Any sample that agrees with the filtered level restarts the run.
            if (r_sync == r_filt) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_W'(FILTER_LEN - 1)) begin
                r_filt <= r_sync;
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_filt = r_filt;

endmodule
`default_nettype wire

// File: rtl/ps2_key_decoder.sv
`default_nettype none
// ============================================================================
// Module   : ps2_key_decoder
// Purpose  : Assembles PS/2 device-to-host frames into bytes. It resolves the
//            E0/F0/E1 prefixes and publishes one 11-bit key event word per
//            key code. The consumer detects a new event when bit 10 changes.
// Ports    : clk_sys  in  system clock
//            reset    in  synchronous active-high reset
//            bus      slave modport of ps2_key_decoder_if
//                     (ps2_clk_in, ps2_data_in, ps2_key, frame_err)
// Revision : 1.0  initial release
// ============================================================================
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic              clk_sys,
    input  logic              reset,
    ps2_key_decoder_if.slave  bus
);
    localparam int TO_W = $clog2(TIMEOUT_CYC);

    localparam logic [1:0] S_IDLE   = 2'(IDLE);
    localparam logic [1:0] S_DATA   = 2'(DATA);
    localparam logic [1:0] S_PARITY = 2'(PARITY);
    localparam logic [1:0] S_STOP   = 2'(STOP);

    logic            w_clk_filt;
    logic            w_data_filt;
    logic            w_timeout;
    logic            r_clk_prev;
    logic            r_fall;
    logic [1:0]      r_state;
    logic [2:0]      r_bit_cnt;
    logic [7:0]      r_shift;
    logic            r_parity;
    logic [TO_W-1:0] r_to_cnt;
    logic [7:0]      r_byte;
    logic            r_byte_vld;
    logic            r_ext;
    logic            r_brk;
    logic [2:0]      r_skip;
    logic [10:0]     r_key;
    logic            r_frame_err;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .clk_sys (clk_sys),
        .reset   (reset),
        .i_line  (bus.ps2_clk_in),
        .o_filt  (w_clk_filt)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
        .clk_sys (clk_sys),
        .reset   (reset),
        .i_line  (bus.ps2_data_in),
        .o_filt  (w_data_filt)
    );

    // The falling edge of the filtered clock is a registered one-cycle strobe.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_clk_prev <= 1'b1;
            r_fall     <= 1'b0;
        end else begin
            r_clk_prev <= w_clk_filt;
            r_fall     <= r_clk_prev & ~w_clk_filt;
        end
    end

    assign w_timeout = (r_state != S_IDLE) && (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));

    // Frame FSM. The timeout takes priority over a fall edge in the same cycle.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_bit_cnt   <= 3'd0;
            r_shift     <= 8'h00;
            r_parity    <= 1'b0;
            r_to_cnt    <= '0;
            r_byte      <= 8'h00;
            r_byte_vld  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            r_byte_vld  <= 1'b0;

            if (r_fall || r_state == S_IDLE)
                r_to_cnt <= '0;
            else
                r_to_cnt <= r_to_cnt + 1'b1;

            if (w_timeout) begin
                r_state     <= S_IDLE;
                r_frame_err <= 1'b1;
                r_to_cnt    <= '0;
            end else if (r_fall) begin
                case (r_state)
                    S_IDLE: begin
                        if (!w_data_filt) begin
                            r_state   <= S_DATA;
                            r_bit_cnt <= 3'd0;
                        end else begin
                            r_frame_err <= 1'b1;
                        end
                    end
                    S_DATA: begin
                        r_shift   <= {w_data_filt, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7)
                            r_state <= S_PARITY;
                    end
                    S_PARITY: begin
                        r_parity <= w_data_filt;
                        r_state  <= S_STOP;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        // Odd parity over data+parity, and the stop bit must be high.
                        if (((^r_shift) ^ r_parity) && w_data_filt) begin
                            r_byte     <= r_shift;
                            r_byte_vld <= 1'b1;
                        end else begin
                            r_frame_err <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    // Byte interpretation: prefix tracking, pause-sequence skipping, event output.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_ext  <= 1'b0;
            r_brk  <= 1'b0;
            r_skip <= 3'd0;
            r_key  <= 11'h000;
        end else begin
            if (r_byte_vld) begin
                if (r_skip != 3'd0) begin
                    r_skip <= r_skip - 3'd1;
                end else if (r_byte == PS2_PAUSE) begin
                    r_skip <= PAUSE_SKIP;
                end else if (r_byte == PS2_EXT) begin
                    r_ext <= 1'b1;
                end else if (r_byte == PS2_BRK) begin
                    r_brk <= 1'b1;
                end else if (is_response(r_byte) && !r_ext && !r_brk) begin
                    r_key <= r_key;
                end else begin
                    r_key <= {~r_key[10], ~r_brk, r_ext, r_byte};
                    r_ext <= 1'b0;
                    r_brk <= 1'b0;
                end
            end
            // A broken frame leaves any pending prefix meaningless.
            if (r_frame_err) begin
                r_ext  <= 1'b0;
                r_brk  <= 1'b0;
                r_skip <= 3'd0;
            end
        end
    end

    assign bus.ps2_key   = r_key;
    assign bus.frame_err = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_key_decoder
// Purpose  : Directed self-checking bench for ps2_key_decoder. It drives PS/2
//            frames with hand-computed expected event words and error counts.
// Revision : 1.0  initial release
// ============================================================================
module tb_ps2_key_decoder;
    localparam int HALF = 20;    // clk_sys cycles per PS/2 clock half-period
    localparam int TO   = 1000;  // reduced timeout for this bench

    logic clk_sys = 1'b0;
    logic reset   = 1'b1;

    ps2_key_decoder_if bus ();

    ps2_key_decoder #(.FILTER_LEN(8), .TIMEOUT_CYC(TO)) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 clk_sys = ~clk_sys;

    int   n_checks   = 0;
    int   n_errors   = 0;
    int   err_pulses = 0;
    int   err_long   = 0;
    logic err_prev   = 1'b0;
    bit   glitch_en  = 1'b0;

    always @(negedge clk_sys) begin
        if (bus.frame_err) err_pulses++;
        if (bus.frame_err && err_prev) err_long++;
        err_prev = bus.frame_err;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic ps2_bit(input logic b);
        bus.ps2_data_in = b;
        if (glitch_en) begin
            wait_clk(HALF / 2);
            bus.ps2_clk_in = 1'b0;
            wait_clk(1);
            bus.ps2_clk_in = 1'b1;
            wait_clk(HALF - HALF / 2 - 1);
        end else begin
            wait_clk(HALF);
        end
        bus.ps2_clk_in = 1'b0;
        wait_clk(HALF);
        bus.ps2_clk_in = 1'b1;
    endtask

    task automatic send_raw(input logic [7:0] b, input logic par, input logic stp);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(par);
        ps2_bit(stp);
        bus.ps2_data_in = 1'b1;
        wait_clk(60);
    endtask

    task automatic send(input logic [7:0] b);
        send_raw(b, ~^b, 1'b1);
    endtask

    task automatic check_key(input string tag, input logic [10:0] exp);
        @(negedge clk_sys);
        check_eq(tag, {21'd0, bus.ps2_key}, {21'd0, exp});
    endtask

    initial begin
        int e0;
        bus.ps2_clk_in  = 1'b1;
        bus.ps2_data_in = 1'b1;
        wait_clk(5);
        @(negedge clk_sys);
        check_eq("reset_key", {21'd0, bus.ps2_key}, 32'h0);
        check_eq("reset_err", {31'd0, bus.frame_err}, 32'h0);
        reset = 1'b0;
        wait_clk(20);

        e0 = err_pulses;
        send(8'h1C);
        check_key("make_1C", 11'h61C);
        check_eq("make_1C_err", err_pulses - e0, 0);

        send(8'hF0);
        check_key("brk_prefix_no_event", 11'h61C);
        send(8'h1C);
        check_key("break_1C", 11'h01C);

        send(8'hE0); send(8'hF0); send(8'h75);
        check_key("ext_break_75", 11'h575);
        check_eq("ext_break_75_low", {22'd0, bus.ps2_key[9:0]}, 32'h175);
        send(8'h75);
        check_key("bare_75", 11'h275);

        e0 = err_pulses;
        send(8'hE0);
        send_raw(8'h1C, 1'b1, 1'b1);
        check_key("parity_err_key", 11'h275);
        check_eq("parity_err_pulse", err_pulses - e0, 1);
        send(8'h1C);
        check_key("after_parity_no_stale_ext", 11'h61C);

        e0 = err_pulses;
        send(8'hF0);
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(i[0]);
        bus.ps2_data_in = 1'b1;
        wait_clk(TO + 100);
        check_eq("timeout_pulse", err_pulses - e0, 1);
        check_key("timeout_key", 11'h61C);
        send(8'h33);
        check_key("after_timeout_33", 11'h233);

        e0 = err_pulses;
        glitch_en = 1'b1;
        send(8'h4B);
        glitch_en = 1'b0;
        check_key("glitch_4B", 11'h64B);
        check_eq("glitch_err", err_pulses - e0, 0);

        e0 = err_pulses;
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
        check_key("pause_no_event", 11'h64B);
        check_eq("pause_err", err_pulses - e0, 0);

        send(8'hFA);
        check_key("response_dropped", 11'h64B);
        send(8'h1C);
        check_key("after_response_1C", 11'h21C);

        e0 = err_pulses;
        send_raw(8'h1C, 1'b0, 1'b0);
        check_eq("stop_err_pulse", err_pulses - e0, 1);
        check_key("stop_err_key", 11'h21C);

        e0 = err_pulses;
        ps2_bit(1'b1);
        bus.ps2_data_in = 1'b1;
        wait_clk(60);
        check_eq("bad_start_pulse", err_pulses - e0, 1);

        e0 = err_pulses;
        ps2_bit(1'b0);
        for (int i = 0; i < 3; i++) ps2_bit(1'b1);
        reset = 1'b1;
        wait_clk(3);
        reset = 1'b0;
        wait_clk(100);
        check_key("midframe_reset_key", 11'h000);
        check_eq("midframe_reset_err", err_pulses - e0, 0);
        send(8'h1C);
        check_key("after_reset_1C", 11'h61C);

        check_eq("err_pulse_width", err_long, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
